// File: rtl/ram_master_if.sv
// Core/RAM bundle for ram_master: request and response toward the pipeline,
// plus the word-wide RAM port. The master modport is the ram_master view.
interface ram_master_if;
    logic        req;
    logic        we;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic        ack;
    logic        err;
    logic [31:0] rdata;
    logic [31:0] ram_addr;
    logic [31:0] ram_wdata;
    logic        ram_rden;
    logic        ram_wren;
    logic [31:0] ram_rdata;

    modport master (
        input  req, we, funct3, addr, wdata, ram_rdata,
        output busy, ack, err, rdata, ram_addr, ram_wdata, ram_rden, ram_wren
    );

    modport slave (
        output req, we, funct3, addr, wdata, ram_rdata,
        input  busy, ack, err, rdata, ram_addr, ram_wdata, ram_rden, ram_wren
    );
endinterface

// File: rtl/ram_master.sv
// RV32I load/store initiator for a word-wide RAM without byte enables:
// lane extraction and extension on loads, read-modify-write on sub-word stores.
module ram_master (
    input  logic         m_clock,
    input  logic         p_reset,
    ram_master_if.master bus
);
    localparam int unsigned XLEN = 32;
    localparam int unsigned HALF = 16;
    localparam int unsigned BYTE = 8;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        RD_ISSUE   = 3'd1,
        RD_CAPTURE = 3'd2,
        WR_ISSUE   = 3'd3,
        ACK        = 3'd4
    } state_t;

    // Request fields kept for the life of one access; only the low half of
    // wdata matters for read-modify-write.
    typedef struct packed {
        logic            we;
        logic [2:0]      funct3;
        logic [1:0]      lane;
        logic [HALF-1:0] wdata;
    } req_t;

    state_t state_q, state_d;
    req_t   req_q;

    logic            busy_q, ack_q, err_q, rden_q, wren_q;
    logic [XLEN-1:0] rdata_q, ram_addr_q, ram_wdata_q;

    logic            accept_c, bad_c, bad_f3_c, misalign_c;
    logic [BYTE-1:0] byte_c;
    logic [HALF-1:0] half_c;
    logic [XLEN-1:0] load_c, merge_c;

    // Legality of the incoming request
    always_comb begin
        bad_f3_c   = (bus.funct3 == 3'b011) || (bus.funct3[2] && (bus.funct3[1] || bus.we));
        misalign_c = ((bus.funct3[1:0] == 2'b01) && bus.addr[0])
                  || ((bus.funct3[1:0] == 2'b10) && (bus.addr[1:0] != 2'b00));
        bad_c      = bad_f3_c || misalign_c;
    end

    // Lane extraction, extension and merge against the captured RAM word
    always_comb begin
        byte_c  = bus.ram_rdata[{req_q.lane, 3'b000} +: BYTE];
        half_c  = bus.ram_rdata[{req_q.lane[1], 4'b0000} +: HALF];
        load_c  = bus.ram_rdata;
        merge_c = bus.ram_rdata;
        case (req_q.funct3)
            F3_B:    load_c = {{(XLEN-BYTE){byte_c[BYTE-1]}}, byte_c};
            F3_BU:   load_c = {{(XLEN-BYTE){1'b0}}, byte_c};
            F3_H:    load_c = {{(XLEN-HALF){half_c[HALF-1]}}, half_c};
            F3_HU:   load_c = {{(XLEN-HALF){1'b0}}, half_c};
            default: load_c = bus.ram_rdata;
        endcase
        if (req_q.funct3[1:0] == 2'b00) begin
            merge_c[{req_q.lane, 3'b000} +: BYTE] = req_q.wdata[BYTE-1:0];
        end else if (req_q.funct3[1:0] == 2'b01) begin
            merge_c[{req_q.lane[1], 4'b0000} +: HALF] = req_q.wdata;
        end
    end

    // Next-state logic
    always_comb begin
        state_d  = state_q;
        accept_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.req) begin
                    accept_c = 1'b1;
                    if (bad_c) begin
                        state_d = ACK;
                    end else if (bus.we && (bus.funct3 == F3_W)) begin
                        state_d = WR_ISSUE;
                    end else begin
                        state_d = RD_ISSUE;
                    end
                end
            end
            RD_ISSUE:   state_d = RD_CAPTURE;
            RD_CAPTURE: state_d = req_q.we ? WR_ISSUE : ACK;
            WR_ISSUE:   state_d = ACK;
            ACK:        state_d = IDLE;
            default:    state_d = IDLE;
        endcase
    end

    // State plus outputs registered from the next state, so strobes line up with it
    always_ff @(posedge m_clock) begin
        if (!p_reset) begin
            state_q     <= IDLE;
            req_q       <= '0;
            busy_q      <= 1'b0;
            ack_q       <= 1'b0;
            err_q       <= 1'b0;
            rden_q      <= 1'b0;
            wren_q      <= 1'b0;
            rdata_q     <= '0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
        end else begin
            state_q <= state_d;
            busy_q  <= (state_d != IDLE);
            ack_q   <= (state_d == ACK);
            // ACK is entered straight from IDLE only for a rejected request
            err_q   <= (state_d == ACK) && accept_c && bad_c;
            rden_q  <= (state_d == RD_ISSUE);
            wren_q  <= (state_d == WR_ISSUE);
            if (accept_c) begin
                req_q <= '{we: bus.we, funct3: bus.funct3, lane: bus.addr[1:0],
                           wdata: bus.wdata[HALF-1:0]};
                if (!bad_c) begin
                    ram_addr_q <= {2'b00, bus.addr[XLEN-1:2]};
                    if (bus.we && (bus.funct3 == F3_W)) begin
                        ram_wdata_q <= bus.wdata;
                    end
                end
            end
            if (state_q == RD_CAPTURE) begin
                if (req_q.we) begin
                    ram_wdata_q <= merge_c;
                end else begin
                    rdata_q <= load_c;
                end
            end
        end
    end

    assign bus.busy      = busy_q;
    assign bus.ack       = ack_q;
    assign bus.err       = err_q;
    assign bus.rdata     = rdata_q;
    assign bus.ram_addr  = ram_addr_q;
    assign bus.ram_wdata = ram_wdata_q;
    assign bus.ram_rden  = rden_q;
    assign bus.ram_wren  = wren_q;
endmodule

// File: tb/tb_ram_master.sv
// Directed bench for ram_master with a small behavioural RAM behind the port.
module tb_ram_master;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    ram_master_if bus ();
    ram_master dut (.m_clock(clk), .p_reset(rst_n), .bus(bus));

    logic [31:0] mem [16];
    logic        pre_we;
    logic [3:0]  pre_idx;
    logic [31:0] pre_val;
    int rden_total = 0;
    int wren_total = 0;
    int ack_total  = 0;
    int both_total = 0;
    int n_cmp = 0;
    int n_fail = 0;

    // RAM model: one-cycle read latency, write on the enable edge
    always @(posedge clk) begin
        if (pre_we) mem[pre_idx] <= pre_val;
        else if (bus.ram_wren) mem[bus.ram_addr[3:0]] <= bus.ram_wdata;
        if (bus.ram_rden) bus.ram_rdata <= mem[bus.ram_addr[3:0]];
        if (bus.ram_rden) rden_total++;
        if (bus.ram_wren) wren_total++;
        if (bus.ack) ack_total++;
        if (bus.ram_rden && bus.ram_wren) both_total++;
    end

    task automatic preload(input logic [3:0] idx, input logic [31:0] val);
        @(negedge clk);
        pre_we = 1'b1; pre_idx = idx; pre_val = val;
        @(negedge clk);
        pre_we = 1'b0;
    endtask

    // Issue one request and record the cycle (after the sampling edge) of each strobe
    task automatic do_txn(input logic w, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] d, output int rd_c, output int wr_c,
                          output int ack_c, output logic e, output logic [31:0] wd,
                          output logic [31:0] ra, output logic busy_ok,
                          output logic idle_after);
        rd_c = -1; wr_c = -1; ack_c = -1; e = 1'bx; wd = 'x; ra = 'x;
        busy_ok = 1'b1; idle_after = 1'b0;
        @(negedge clk);
        bus.req = 1'b1; bus.we = w; bus.funct3 = f3; bus.addr = a; bus.wdata = d;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (c == 1) bus.req = 1'b0;
            if (!bus.busy) busy_ok = 1'b0;
            if (bus.ram_rden && rd_c < 0) begin rd_c = c; ra = bus.ram_addr; end
            if (bus.ram_wren) begin wr_c = c; wd = bus.ram_wdata; end
            if (bus.ack) begin ack_c = c; e = bus.err; break; end
        end
        @(negedge clk);
        idle_after = !bus.busy && !bus.ack;
    endtask

    int rd_c, wr_c, ack_c;
    logic e, busy_ok, idle_after;
    logic [31:0] wd, ra;

    task automatic test_reset();
        rst_n = 1'b0; bus.req = 1'b0; bus.we = 1'b0; bus.funct3 = 3'b000;
        bus.addr = '0; bus.wdata = '0; pre_we = 1'b0; pre_idx = '0; pre_val = '0;
        repeat (3) @(negedge clk);
        n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        n_cmp++; if (bus.ack !== 1'b0 || bus.err !== 1'b0) begin n_fail++; $display("FAIL reset_ack_err: got %b%b want 00", bus.ack, bus.err); end
        n_cmp++; if (bus.ram_rden !== 1'b0 || bus.ram_wren !== 1'b0) begin n_fail++; $display("FAIL reset_en: got %b%b want 00", bus.ram_rden, bus.ram_wren); end
        n_cmp++; if (bus.rdata !== 32'h0 || bus.ram_addr !== 32'h0 || bus.ram_wdata !== 32'h0) begin n_fail++; $display("FAIL reset_data: got %h %h %h want zeros", bus.rdata, bus.ram_addr, bus.ram_wdata); end
        preload(4'd5, 32'h8899AABB);
        preload(4'd6, 32'h11223344);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_load_word();
        do_txn(1'b0, 3'b010, 32'h14, 32'h0, rd_c, wr_c, ack_c, e, wd, ra, busy_ok, idle_after);
        n_cmp++; if (rd_c !== 1) begin n_fail++; $display("FAIL lw_rden_cycle: got %0d want 1", rd_c); end
        n_cmp++; if (ra !== 32'd5) begin n_fail++; $display("FAIL lw_ram_addr: got %h want 5", ra); end
        n_cmp++; if (ack_c !== 3) begin n_fail++; $display("FAIL lw_ack_cycle: got %0d want 3", ack_c); end
        n_cmp++; if (e !== 1'b0) begin n_fail++; $display("FAIL lw_err: got %b want 0", e); end
        n_cmp++; if (bus.rdata !== 32'h8899AABB) begin n_fail++; $display("FAIL lw_rdata: got %h want 8899aabb", bus.rdata); end
        n_cmp++; if (wr_c !== -1) begin n_fail++; $display("FAIL lw_no_wren: got %0d want -1", wr_c); end
        n_cmp++; if (busy_ok !== 1'b1 || idle_after !== 1'b1) begin n_fail++; $display("FAIL lw_busy: got %b%b want 11", busy_ok, idle_after); end
    endtask

    task automatic test_subword_load();
        logic [2:0]  f3s [6] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b000, 3'b100};
        logic [31:0] adrs[6] = '{32'h16, 32'h16, 32'h16, 32'h14, 32'h14, 32'h17};
        logic [31:0] exps[6] = '{32'hFFFFFF99, 32'h00000099, 32'hFFFF8899,
                                 32'h0000AABB, 32'hFFFFFFBB, 32'h00000088};
        for (int i = 0; i < 6; i++) begin
            do_txn(1'b0, f3s[i], adrs[i], 32'h0, rd_c, wr_c, ack_c, e, wd, ra, busy_ok, idle_after);
            n_cmp++; if (bus.rdata !== exps[i] || ack_c !== 3 || e !== 1'b0) begin n_fail++; $display("FAIL subload_%0d: got %h ack@%0d err %b want %h ack@3 err 0", i, bus.rdata, ack_c, e, exps[i]); end
        end
    endtask

    task automatic test_store();
        do_txn(1'b1, 3'b000, 32'h15, 32'h12345677, rd_c, wr_c, ack_c, e, wd, ra, busy_ok, idle_after);
        n_cmp++; if (rd_c !== 1 || wr_c !== 3 || ack_c !== 4) begin n_fail++; $display("FAIL sb_timing: got rd%0d wr%0d ack%0d want rd1 wr3 ack4", rd_c, wr_c, ack_c); end
        n_cmp++; if (wd !== 32'h889977BB) begin n_fail++; $display("FAIL sb_wdata: got %h want 889977bb", wd); end
        n_cmp++; if (bus.rdata !== 32'h00000088) begin n_fail++; $display("FAIL sb_rdata_kept: got %h want 00000088", bus.rdata); end
        do_txn(1'b0, 3'b010, 32'h14, 32'h0, rd_c, wr_c, ack_c, e, wd, ra, busy_ok, idle_after);
        n_cmp++; if (bus.rdata !== 32'h889977BB) begin n_fail++; $display("FAIL sb_readback: got %h want 889977bb", bus.rdata); end
        do_txn(1'b1, 3'b001, 32'h1A, 32'hDEADBEEF, rd_c, wr_c, ack_c, e, wd, ra, busy_ok, idle_after);
        n_cmp++; if (wd !== 32'hBEEF3344 || wr_c !== 3 || ack_c !== 4) begin n_fail++; $display("FAIL sh_merge: got %h wr%0d ack%0d want beef3344 wr3 ack4", wd, wr_c, ack_c); end
        do_txn(1'b1, 3'b010, 32'h18, 32'hCAFEF00D, rd_c, wr_c, ack_c, e, wd, ra, busy_ok, idle_after);
        n_cmp++; if (rd_c !== -1 || wr_c !== 1 || ack_c !== 2 || wd !== 32'hCAFEF00D) begin n_fail++; $display("FAIL sw: got rd%0d wr%0d ack%0d %h want rd-1 wr1 ack2 cafef00d", rd_c, wr_c, ack_c, wd); end
        n_cmp++; if (mem[6] !== 32'hCAFEF00D) begin n_fail++; $display("FAIL sw_mem: got %h want cafef00d", mem[6]); end
    endtask

    task automatic test_errors();
        logic        ws  [3] = '{1'b0, 1'b1, 1'b1};
        logic [2:0]  f3s [3] = '{3'b001, 3'b010, 3'b100};
        logic [31:0] adrs[3] = '{32'h13, 32'h12, 32'h14};
        logic [31:0] keep;
        keep = bus.rdata;
        for (int i = 0; i < 3; i++) begin
            do_txn(ws[i], f3s[i], adrs[i], 32'hFFFFFFFF, rd_c, wr_c, ack_c, e, wd, ra, busy_ok, idle_after);
            n_cmp++; if (ack_c !== 1 || e !== 1'b1) begin n_fail++; $display("FAIL err_%0d_ack: got ack@%0d err %b want ack@1 err 1", i, ack_c, e); end
            n_cmp++; if (rd_c !== -1 || wr_c !== -1 || bus.rdata !== keep) begin n_fail++; $display("FAIL err_%0d_side: got rd%0d wr%0d %h want -1 -1 %h", i, rd_c, wr_c, bus.rdata, keep); end
        end
    endtask

    task automatic test_reset_mid();
        int w0, a0;
        w0 = wren_total; a0 = ack_total;
        @(negedge clk);
        bus.req = 1'b1; bus.we = 1'b1; bus.funct3 = 3'b001; bus.addr = 32'h14; bus.wdata = 32'h5555;
        @(negedge clk);
        bus.req = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        repeat (4) @(negedge clk);
        n_cmp++; if (wren_total !== w0 || ack_total !== a0) begin n_fail++; $display("FAIL rstmid_strobes: got wren+%0d ack+%0d want 0 0", wren_total - w0, ack_total - a0); end
        n_cmp++; if ({bus.busy, bus.ack, bus.err, bus.ram_rden, bus.ram_wren} !== 5'b0) begin n_fail++; $display("FAIL rstmid_ctrl: got %b want 00000", {bus.busy, bus.ack, bus.err, bus.ram_rden, bus.ram_wren}); end
        n_cmp++; if (bus.rdata !== 32'h0 || bus.ram_addr !== 32'h0 || bus.ram_wdata !== 32'h0) begin n_fail++; $display("FAIL rstmid_data: got %h %h %h want zeros", bus.rdata, bus.ram_addr, bus.ram_wdata); end
        rst_n = 1'b1;
        do_txn(1'b0, 3'b010, 32'h14, 32'h0, rd_c, wr_c, ack_c, e, wd, ra, busy_ok, idle_after);
        n_cmp++; if (bus.rdata !== 32'h889977BB) begin n_fail++; $display("FAIL rstmid_readback: got %h want 889977bb", bus.rdata); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exps[4] = '{32'h889977BB, 32'hCAFEF00D, 32'h889977BB, 32'hCAFEF00D};
        int acks[4];
        logic [31:0] got[4];
        int n, r0;
        n = 0; r0 = rden_total;
        @(negedge clk);
        bus.req = 1'b1; bus.we = 1'b0; bus.funct3 = 3'b010; bus.addr = 32'h14;
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            if (bus.ack) begin
                if (n < 4) begin acks[n] = c; got[n] = bus.rdata; end
                n++;
                bus.addr = (bus.addr == 32'h14) ? 32'h18 : 32'h14;
            end
        end
        bus.req = 1'b0;
        n_cmp++; if (n !== 4 || rden_total - r0 !== 4) begin n_fail++; $display("FAIL b2b_count: got ack %0d rden %0d want 4 4", n, rden_total - r0); end
        for (int i = 0; i < 4; i++) begin
            if (i < n) begin
                n_cmp++; if (acks[i] !== 4 * i + 3 || got[i] !== exps[i]) begin n_fail++; $display("FAIL b2b_%0d: got ack@%0d %h want ack@%0d %h", i, acks[i], got[i], 4 * i + 3, exps[i]); end
            end
        end
        repeat (6) @(negedge clk);
        n_cmp++; if (both_total !== 0) begin n_fail++; $display("FAIL rden_wren_overlap: got %0d want 0", both_total); end
    endtask

    initial begin
        test_reset();
        test_load_word();
        test_subword_load();
        test_store();
        test_errors();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/ram_master.md
# ram_master

Core-side initiator for the word-wide on-chip RAM port (addr / wdata / rden / wren / rdata). Accepts one RV32I load or store per request from the execute stage and drives the RAM with registered control. Sub-word accesses are handled with byte-lane extraction and sign/zero extension on loads, and with read-modify-write on stores, since the RAM has no byte enables. Sits between the core pipeline and the RAM wrapper.

## Interface
Parameters:
- none (RAM word address passes through unmasked; the RAM wrapper truncates)

Ports:
- m_clock  in  1  clock; all state updates on rising edge
- p_reset  in  1  reset, synchronous, active-low
- req  in  1  request strobe; sampled only in IDLE
- we  in  1  1 = store, 0 = load
- funct3  in  3  RV32I width/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- addr  in  32  byte address
- wdata  in  32  store data, right-aligned
- busy  out  1  high in every state except IDLE
- ack  out  1  one-cycle completion pulse
- err  out  1  valid with ack; misaligned or illegal funct3
- rdata  out  32  load result, extended; held until next load ack
- ram_addr  out  32  word address {2'b00, addr[31:2]}
- ram_wdata  out  32  word to RAM
- ram_rden  out  1  RAM read enable
- ram_wren  out  1  RAM write enable
- ram_rdata  in  32  RAM read word; valid the cycle after ram_rden

## Operation
- States: IDLE, RD_ISSUE, RD_CAPTURE, WR_ISSUE, ACK.
- IDLE, req=1: latch we, funct3, addr, wdata. Check legality:
  - Illegal funct3: 011, 110, 111; also 100 or 101 with we=1.
  - Misaligned: H/HU with addr[0]=1; W with addr[1:0]!=0.
  - If illegal or misaligned: go to ACK with err=1. No RAM access is made.
  - Legal load, or store B/H: go to RD_ISSUE.
  - Legal store W: go to WR_ISSUE with ram_wdata = wdata.
- RD_ISSUE: ram_rden=1 for exactly one cycle; go to RD_CAPTURE.
- RD_CAPTURE: ram_rdata is valid; capture the word.
  - Load: extract the lane, extend it, register into rdata; go to ACK.
  - Store: merge wdata into the lane, place the merged word on ram_wdata; go to WR_ISSUE.
- WR_ISSUE: ram_wren=1 for exactly one cycle; go to ACK.
- ACK: ack=1 for one cycle; err as determined in IDLE; go to IDLE.
- Lanes (little-endian):
  - Byte lane k = addr[1:0], bits [8k+7:8k].
  - Half lane = addr[1], bits [16*addr[1]+15 : 16*addr[1]].
- Extension:
  - B and H: sign-extend from bit 7 / bit 15.
  - BU and HU: zero-extend.
  - W: as read.
- Merge: only the selected lane is replaced, using wdata[7:0] or wdata[15:0]. All other bytes keep the RAM value.
- ram_addr is held stable from RD_ISSUE through WR_ISSUE.
- req while busy=1 is ignored; it is not queued.
- rdata is updated only on a successful load. A store ack or an err ack leaves rdata unchanged.

## Timing
- Reset (p_reset=0 at an edge):
  - State goes to IDLE.
  - busy, ack, err, ram_rden, ram_wren = 0.
  - rdata, ram_addr, ram_wdata = 0.
- Reset mid-operation: takes effect at the same edge. Any pending ram_wren is dropped, so a read-modify-write is aborted before its write. No ack is produced for the aborted request.
- All outputs are registered. Cycle 0 is the edge at which req is sampled in IDLE.
  - Load: ram_rden in cycle 1; ack and rdata in cycle 3.
  - Store W: ram_wren in cycle 1; ack in cycle 2.
  - Store B/H: ram_rden in cycle 1; ram_wren in cycle 3; ack in cycle 4.
  - Error: ack and err in cycle 1.
- busy is high from cycle 1 through the ack cycle inclusive. It is low the cycle after ack, so the earliest next req is sampled one cycle after ack.
- ram_rden and ram_wren are never high in the same cycle.

## Test plan
- RAM word 5 = 0x8899AABB; load funct3=010, addr=0x14 -> ram_addr=5, ram_rden in cycle 1, ack in cycle 3, rdata=0x8899AABB, err=0.
- Same word; LB at addr=0x16 -> rdata=0xFFFFFF99. LBU at addr=0x16 -> 0x00000099. LH at addr=0x16 -> 0xFFFF8899.
- Word 5 = 0x8899AABB; SB addr=0x15, wdata=0x12345677 -> ram_wren in cycle 3 with ram_wdata=0x8899 77BB (0x889977BB); ack in cycle 4. Readback LW = 0x889977BB.
- LH at addr=0x13; SW at addr=0x12; funct3=100 with we=1 -> each gives ack+err in cycle 1, no ram_rden/ram_wren, rdata unchanged.
- Start SH at addr=0x14; drive p_reset=0 in cycle 2 -> no ram_wren at any time, no ack, all outputs 0. RAM word unchanged on readback.
- Hold req=1 continuously with alternating LW -> each request is accepted only in IDLE, one ack per 4-cycle period, no requests are lost or duplicated while busy.
